// File: rtl/btn_gesture.sv
`default_nettype none
// ============================================================================
// btn_gesture : N-channel button front-end (sync, debounce, arm, long/multi-click) -> event FIFO
// Rev 1.0
// ============================================================================
module btn_gesture #(
    parameter int               N_BTN      = 2,
    parameter logic [N_BTN-1:0] ACTIVE_LOW = {N_BTN{1'b1}},
    parameter int               SAMP_TW    = 7,
    parameter int               DEB_LEN    = 4,
    parameter int               ARM_TW     = 15,
    parameter int               LONG_TW    = 17,
    parameter int               CLICK_TW   = 15,
    parameter int               MAX_CLICKS = 3,
    parameter int               FIFO_DEPTH = 4,
    localparam int              CHW        = (N_BTN > 1) ? $clog2(N_BTN) : 1,
    localparam int              CLW        = $clog2(MAX_CLICKS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_val,
    output logic [N_BTN-1:0] btn_armed,
    output logic [N_BTN-1:0] hold_long,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CHW-1:0]   evt_chan,
    output logic             evt_long,
    output logic [CLW-1:0]   evt_clicks,
    output logic             evt_ovf,
    input  logic             ovf_clr
);

    localparam int                 c_AW        = $clog2(FIFO_DEPTH);
    localparam int                 c_EW        = CHW + 1 + CLW;
    localparam logic [3:0]         c_DEB_LAST  = 4'(DEB_LEN - 1);
    localparam logic [ARM_TW:0]    c_ARM_LAST  = {1'b0, {ARM_TW{1'b1}}};
    localparam logic [LONG_TW:0]   c_LONG_MAX  = {1'b1, {LONG_TW{1'b0}}};
    localparam logic [CLW-1:0]     c_MAXC      = CLW'(MAX_CLICKS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    logic [SAMP_TW-1:0] r_presc;
    logic               w_samp;
    logic [N_BTN-1:0]   w_pend, w_pend_long, w_drop, w_grant;
    logic [CLW-1:0]     w_pend_clicks [N_BTN];
    logic               w_any, w_push, w_pop, w_empty, w_full;
    logic [CHW-1:0]     w_sel;
    logic [c_EW-1:0]    w_entry, w_head;
    logic [c_EW-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW:0]      r_wr, r_rd;
    logic               r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_presc <= '0;
        else     r_presc <= r_presc + SAMP_TW'(1);
    end
    assign w_samp = &r_presc;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        logic [1:0]          r_sync;
        logic                r_val, r_armed;
        logic [3:0]          r_deb;
        logic [ARM_TW:0]     r_arm_cnt;
        logic [LONG_TW:0]    r_hold;
        state_t              r_state, w_state_nxt;
        logic [CLW-1:0]      r_clicks, w_clicks_nxt, r_pend_clicks;
        logic [CLICK_TW-1:0] r_gap, w_gap_nxt;
        logic                w_emit, w_emit_long, r_pend, r_pend_long;
        logic                w_lvl, w_val_nxt, w_hold_sat;

        assign w_lvl      = r_sync[1] ^ ACTIVE_LOW[gi];
        assign w_val_nxt  = (w_samp && (w_lvl != r_val) && (r_deb == c_DEB_LAST)) ? ~r_val : r_val;
        assign w_hold_sat = (r_hold == c_LONG_MAX);

        // Arming and hold counting see the freshly debounced level of this sample.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync    <= {2{ACTIVE_LOW[gi]}};
                r_val     <= 1'b0;
                r_deb     <= '0;
                r_arm_cnt <= '0;
                r_armed   <= 1'b0;
                r_hold    <= '0;
            end else begin
                r_sync <= {r_sync[0], btn_in[gi]};
                if (w_samp) begin
                    if ((w_lvl == r_val) || (r_deb == c_DEB_LAST)) r_deb <= '0;
                    else                                           r_deb <= r_deb + 4'd1;
                    r_val <= w_val_nxt;
                    if (!w_val_nxt) begin
                        r_hold <= '0;
                        if (!r_armed) begin
                            r_arm_cnt <= r_arm_cnt + (ARM_TW + 1)'(1);
                            if (r_arm_cnt == c_ARM_LAST) r_armed <= 1'b1;
                        end
                    end else begin
                        if (!r_armed)    r_arm_cnt <= '0;
                        if (!w_hold_sat) r_hold    <= r_hold + (LONG_TW + 1)'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state  <= ST_IDLE;
                r_clicks <= '0;
                r_gap    <= '0;
            end else begin
                r_state  <= w_state_nxt;
                r_clicks <= w_clicks_nxt;
                r_gap    <= w_gap_nxt;
            end
        end

        always_comb begin
            w_state_nxt  = r_state;
            w_clicks_nxt = r_clicks;
            w_gap_nxt    = r_gap;
            w_emit       = 1'b0;
            w_emit_long  = 1'b0;
            if (!r_armed) begin
                w_state_nxt = ST_IDLE;
            end else if (w_samp) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_val_nxt) begin
                            w_state_nxt  = ST_PRESSED;
                            w_clicks_nxt = CLW'(1);
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_val_nxt) begin
                            if (w_hold_sat) begin
                                w_emit      = 1'b1;
                                w_emit_long = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else if (r_clicks == c_MAXC) begin
                                w_emit      = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_state_nxt = ST_GAP;
                                w_gap_nxt   = '0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_val_nxt) begin
                            w_clicks_nxt = r_clicks + CLW'(1);
                            w_state_nxt  = ST_PRESSED;
                        end else if (&r_gap) begin
                            w_emit      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_gap_nxt = r_gap + CLICK_TW'(1);
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end

        // One-deep holding slot; a second gesture arriving while occupied is lost.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pend        <= 1'b0;
                r_pend_long   <= 1'b0;
                r_pend_clicks <= '0;
            end else begin
                if (w_grant[gi]) r_pend <= 1'b0;
                if (w_emit && !r_pend) begin
                    r_pend        <= 1'b1;
                    r_pend_long   <= w_emit_long;
                    r_pend_clicks <= r_clicks;
                end
            end
        end

        assign w_pend[gi]        = r_pend;
        assign w_pend_long[gi]   = r_pend_long;
        assign w_pend_clicks[gi] = r_pend_clicks;
        assign w_drop[gi]        = w_emit & r_pend;
        assign btn_val[gi]       = r_val;
        assign btn_armed[gi]     = r_armed;
        assign hold_long[gi]     = r_armed & w_hold_sat;
    end

    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_any = 1'b1;
                w_sel = CHW'(i);
            end
        end
    end

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_pop   = ~w_empty & evt_ready;
    assign w_push  = w_any & (~w_full | w_pop);
    assign w_entry = {w_sel, w_pend_long[w_sel], w_pend_clicks[w_sel]};

    always_comb begin
        for (int i = 0; i < N_BTN; i++) w_grant[i] = w_push && (w_sel == CHW'(i));
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[c_AW-1:0]] <= w_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + (c_AW + 1)'(1);
            if (w_pop)  r_rd <= r_rd + (c_AW + 1)'(1);
            if (|w_drop)     r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    // Storage is not reset, so the head is masked while the queue is empty.
    assign w_head    = r_mem[r_rd[c_AW-1:0]];
    assign evt_valid = ~w_empty;
    assign {evt_chan, evt_long, evt_clicks} = w_empty ? '0 : w_head;
    assign evt_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_btn_gesture.sv
`default_nettype none
`timescale 1ns/1ps
// tb_btn_gesture : directed self-checking bench for btn_gesture (fast-time parameters).
module tb_btn_gesture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_in;
    logic [1:0] btn_val, btn_armed, hold_long;
    logic       evt_valid, evt_ready, evt_chan, evt_long, evt_ovf, ovf_clr;
    logic [1:0] evt_clicks;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btn_gesture #(
        .N_BTN(2), .ACTIVE_LOW(2'b11), .SAMP_TW(2), .DEB_LEN(4), .ARM_TW(4),
        .LONG_TW(6), .CLICK_TW(5), .MAX_CLICKS(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_val(btn_val),
        .btn_armed(btn_armed), .hold_long(hold_long), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_chan(evt_chan), .evt_long(evt_long),
        .evt_clicks(evt_clicks), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_val(input int ch, input logic v, input int bound, output int n);
        n = 0;
        while ((btn_val[ch] !== v) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_val%0d", ch), 32'(btn_val[ch]), 32'(v));
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (!evt_valid && (n < bound)) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", 32'(evt_valid), 32'd1);
    endtask

    task automatic pop_check(input string tag, input int ch, input int lng, input int clk_n);
        chk({tag, "_valid"},  32'(evt_valid),  32'd1);
        chk({tag, "_chan"},   32'(evt_chan),   32'(ch));
        chk({tag, "_long"},   32'(evt_long),   32'(lng));
        chk({tag, "_clicks"}, 32'(evt_clicks), 32'(clk_n));
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic triple(input int ch);
        int n;
        for (int k = 0; k < 3; k++) begin
            btn_in[ch] = 1'b0;
            repeat (40) @(negedge clk);
            btn_in[ch] = 1'b1;
            if (k < 2) repeat (40) @(negedge clk);
        end
        wait_val(ch, 1'b0, 64, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_val"},    32'(btn_val),   32'd0);
        chk({tag, "_armed"},  32'(btn_armed), 32'd0);
        chk({tag, "_hold"},   32'(hold_long), 32'd0);
        chk({tag, "_valid"},  32'(evt_valid), 32'd0);
        chk({tag, "_fields"}, 32'({evt_chan, evt_long, evt_clicks}), 32'd0);
        chk({tag, "_ovf"},    32'(evt_ovf),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        btn_in    = 2'b10;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b0;

        // Pin 0 held from reset: debounced but never arms until released.
        repeat (100) @(negedge clk);
        chk("t1_val0_pressed", 32'(btn_val[0]), 32'd1);
        chk("t1_armed", 32'(btn_armed), 32'd2);
        repeat (100) @(negedge clk);
        btn_in[0] = 1'b1;
        repeat (62) @(negedge clk);
        chk("t1_unarmed_62", 32'(btn_armed[0]), 32'd0);
        chk("t1_val0_released", 32'(btn_val[0]), 32'd0);
        repeat (28) @(negedge clk);
        chk("t1_armed_90", 32'(btn_armed[0]), 32'd1);
        chk("t1_no_event", 32'(evt_valid), 32'd0);

        // 12-cycle glitch spans only three samples.
        repeat (20) @(negedge clk);
        seen = 1'b0;
        btn_in[0] = 1'b0;
        for (int k = 0; k < 42; k++) begin
            if (k == 12) btn_in[0] = 1'b1;
            @(negedge clk);
            seen = seen | btn_val[0];
        end
        chk("t2_glitch", 32'(seen), 32'd0);

        btn_in[0] = 1'b0;
        repeat (40) @(negedge clk);
        btn_in[0] = 1'b1;
        wait_val(0, 1'b0, 64, n);
        n = 0;
        while (!evt_valid && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        chk("t2_latency", 32'(n), 32'd129);
        pop_check("t2_evt", 0, 0, 1);
        chk("t2_popped", 32'(evt_valid), 32'd0);

        // Double click, then triple click emitted at the third release.
        repeat (20) @(negedge clk);
        btn_in[0] = 1'b0; repeat (40) @(negedge clk);
        btn_in[0] = 1'b1; repeat (40) @(negedge clk);
        btn_in[0] = 1'b0; repeat (40) @(negedge clk);
        btn_in[0] = 1'b1;
        wait_valid(400, n);
        pop_check("t3_dbl", 0, 0, 2);
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            btn_in[0] = 1'b0;
            repeat (40) @(negedge clk);
            btn_in[0] = 1'b1;
            if (k < 2) repeat (40) @(negedge clk);
        end
        wait_val(0, 1'b0, 64, n);
        chk("t3_trip_not_yet", 32'(evt_valid), 32'd0);
        @(negedge clk);
        pop_check("t3_trip", 0, 0, 3);

        // Long hold on channel 1.
        repeat (20) @(negedge clk);
        btn_in[1] = 1'b0;
        wait_val(1, 1'b1, 64, n);
        n = 0;
        while (!hold_long[1] && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        chk_rng("t4_long_latency", n, 244, 260);
        chk("t4_hold0", 32'(hold_long[0]), 32'd0);
        repeat (16) @(negedge clk);
        btn_in[1] = 1'b1;
        wait_valid(64, n);
        chk("t4_hold_clear", 32'(hold_long), 32'd0);
        pop_check("t4_evt", 1, 1, 1);

        // Simultaneous long releases, then fill the FIFO and overflow.
        repeat (20) @(negedge clk);
        btn_in = 2'b00;
        repeat (300) @(negedge clk);
        btn_in = 2'b11;
        wait_valid(64, n);
        repeat (3) @(negedge clk);
        chk("t5_head_chan", 32'(evt_chan), 32'd0);
        chk("t5_head_long", 32'(evt_long), 32'd1);
        chk("t5_ovf0", 32'(evt_ovf), 32'd0);
        triple(0);
        triple(0);
        chk("t5_ovf_full", 32'(evt_ovf), 32'd0);
        triple(0);
        chk("t5_ovf_pending", 32'(evt_ovf), 32'd0);
        triple(0);
        chk("t5_ovf_set", 32'(evt_ovf), 32'd1);
        chk("t5_stable_chan", 32'(evt_chan), 32'd0);
        chk("t5_stable_long", 32'(evt_long), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t5_ovf_clr", 32'(evt_ovf), 32'd0);
        pop_check("t5_e0", 0, 1, 1);
        pop_check("t5_e1", 1, 1, 1);
        pop_check("t5_e2", 0, 0, 3);
        pop_check("t5_e3", 0, 0, 3);
        chk("t5_e4_valid", 32'(evt_valid), 32'd1);
        chk("t5_e4_clicks", 32'(evt_clicks), 32'd3);

        // Asynchronous reset while channel 0 sits in the click gap.
        btn_in[0] = 1'b0;
        repeat (40) @(negedge clk);
        btn_in[0] = 1'b1;
        wait_val(0, 1'b0, 64, n);
        repeat (10) @(negedge clk);
        chk("t6_pre_valid", 32'(evt_valid), 32'd1);
        btn_in[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_unarmed", 32'(btn_armed), 32'd0);
        chk("t6_val_pressed", 32'(btn_val[0]), 32'd1);
        repeat (10) @(negedge clk);
        btn_in[0] = 1'b1;
        repeat (260) @(negedge clk);
        chk("t6_no_event", 32'(evt_valid), 32'd0);
        chk("t6_rearmed", 32'(btn_armed), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_gesture.md
Name: btn_gesture

Overview:
Multi-channel button front-end for iCE40 designs. It is the parametrised successor to the single-button debounce/long-press logic. Each of N_BTN inputs gets synchronisation, debounce, boot-press arming, long-press and multi-click (double/triple) detection. Completed gestures are queued in a small event FIFO with a valid/ready output, which user logic or a warmboot controller consumes.

Parameters:
N_BTN, 2, number of button channels
ACTIVE_LOW, {N_BTN{1'b1}}, per-channel invert mask (bit i set = input i active-low)
SAMP_TW, 7, sample tick every 2^SAMP_TW clk cycles
DEB_LEN, 4, consecutive differing samples required to flip debounced state (2..15)
ARM_TW, 15, channel armed after 2^ARM_TW consecutive released samples
LONG_TW, 17, press is long once held for 2^LONG_TW samples
CLICK_TW, 15, inter-click gap timeout of 2^CLICK_TW samples
MAX_CLICKS, 3, maximum clicks counted per gesture (1..7)
FIFO_DEPTH, 4, event FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
btn_in  in  N_BTN  raw button pins (already through IO buffer)
btn_val  out  N_BTN  debounced, polarity-corrected level
btn_armed  out  N_BTN  channel armed
hold_long  out  N_BTN  armed channel currently held >= long threshold
evt_valid  out  1  event available at FIFO head
evt_ready  in  1  consumer accepts head event
evt_chan  out  CHW=max(1,$clog2(N_BTN))  channel index of head event
evt_long  out  1  head event ended with a long hold
evt_clicks  out  CLW=$clog2(MAX_CLICKS+1)  click count of head event (>=1)
evt_ovf  out  1  sticky: an event was dropped
ovf_clr  in  1  clears evt_ovf

Behaviour:
- Reset: all outputs 0, FIFO empty, all counters 0, all channels unarmed, FSMs IDLE.
- Input: 2-flop synchroniser per channel, then XOR with ACTIVE_LOW[i].
- Prescaler: shared counter. samp_now is a 1-cycle pulse every 2^SAMP_TW cycles; first pulse 2^SAMP_TW cycles after reset release.
- Debounce (on samp_now): sample == btn_val clears the counter. Otherwise counter++. On reaching DEB_LEN, btn_val toggles and the counter clears.
- Arming: a released sample increments arm counter. A pressed sample clears it unless armed. Armed is set when the counter hits 2^ARM_TW and stays set until reset.
- Hold counter: clears on release. Increments each pressed sample, saturating at 2^LONG_TW. hold_long = armed & saturated.
- FSM per channel (advances on samp_now using post-debounce btn_val; unarmed channel held in IDLE):
  - IDLE: press -> PRESSED, clicks=1.
  - PRESSED: release & hold saturated -> emit(long=1, clicks) -> IDLE.
  - PRESSED: release & clicks==MAX_CLICKS -> emit(long=0, clicks) -> IDLE.
  - PRESSED: other release -> GAP, gap counter=0.
  - GAP: press -> clicks++ -> PRESSED.
  - GAP: gap counter reaches 2^CLICK_TW -> emit(long=0, clicks) -> IDLE.
- Emit: sets the channel's 1-deep pending register {long, clicks} at the same edge as the FSM transition. If pending is already set, the new event is dropped and evt_ovf is set.
- Arbiter: each cycle, the lowest-index pending channel is written to the FIFO if not full, and its pending clears at that edge. If the FIFO is full, pending holds (no drop).
- FIFO: show-ahead. evt_valid = not empty. Pop on evt_valid & evt_ready. Push and pop in the same cycle on a full FIFO are both allowed. evt_* fields are stable while evt_valid & ~evt_ready.
- Latency: emit at edge E, FIFO write at E+1, evt_valid high after E+1 if FIFO was empty.
- evt_ovf: set by a drop. ovf_clr clears it. A drop in the same cycle as ovf_clr wins (stays set).
- Async rst mid-gesture: everything returns to reset state. Channel must re-arm before new events.

Test Plan:
Params for bench: N_BTN=2, SAMP_TW=2, DEB_LEN=4, ARM_TW=4, LONG_TW=6, CLICK_TW=5, MAX_CLICKS=3, ACTIVE_LOW=2'b11.

1. Pin 0 low from reset for 200 cycles, then released -> no event, btn_armed[0]=0 until 16 released samples (64 cycles) after release, then 1.
2. Armed ch0, 12-cycle low glitch -> btn_val[0] stays 0. Press 40 cycles, release -> single event chan=0, long=0, clicks=1, exactly 32 samples (128 cycles) after the debounced release.
3. Two presses 40 cycles each with a 40-cycle gap -> one event clicks=2, long=0. Three presses -> event clicks=3 emitted at the third release, with no gap wait.
4. Hold ch1 for 300 cycles -> hold_long[1] rises about 64 samples after debounced press. Release -> chan=1, long=1, clicks=1.
5. Both channels finish in the same sample with evt_ready=0 -> FIFO gets ch0 then ch1, evt_ovf=0. A later ch0 gesture fills the FIFO; the next ones go pending and then are dropped -> evt_ovf=1. ovf_clr -> evt_ovf=0.
6. Assert rst in GAP state of ch0 -> all outputs 0, no event emitted, re-arm required.
